// File: rtl/tx_pkt_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tx_pkt_arbiter
// Purpose  : Packet-level round-robin arbiter that shares the TSE transmit
//            Avalon-ST port between two frame sources. Grants are held for
//            whole packets. A beat watchdog truncates runaway frames with an
//            error-flagged EOP and then drains the offending source.
// Revision : 1.0 - initial release
// ============================================================================
module tx_pkt_arbiter #(
  parameter int DATA_W    = 32,
  parameter int EMPTY_W   = 2,
  parameter int MAX_BEATS = 380,  // must not exceed 511 (9-bit beat counter)
  parameter int CNT_W     = 16
) (
  input  logic               sys_clk,
  input  logic               core_reset_n,
  input  logic [DATA_W-1:0]  in0_data,
  input  logic [EMPTY_W-1:0] in0_empty,
  input  logic               in0_valid,
  input  logic               in0_sop,
  input  logic               in0_eop,
  output logic               in0_ready,
  input  logic [DATA_W-1:0]  in1_data,
  input  logic [EMPTY_W-1:0] in1_empty,
  input  logic               in1_valid,
  input  logic               in1_sop,
  input  logic               in1_eop,
  output logic               in1_ready,
  output logic [DATA_W-1:0]  out_data,
  output logic [EMPTY_W-1:0] out_empty,
  output logic               out_valid,
  output logic               out_sop,
  output logic               out_eop,
  output logic               out_error,
  input  logic               out_ready,
  output logic [1:0]         grant,
  output logic               busy,
  output logic [CNT_W-1:0]   pkt_cnt0,
  output logic [CNT_W-1:0]   pkt_cnt1,
  output logic [CNT_W-1:0]   trunc_cnt,
  output logic [CNT_W-1:0]   frame_err_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PASS  = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  // Index of the last beat allowed before the watchdog forces an EOP.
  localparam logic [8:0] c_last_idx = 9'(MAX_BEATS - 1);

  state_t             state_q, state_d;
  logic               g_q, g_d;
  logic               last_g_q, last_g_d;
  logic [8:0]         beat_cnt_q, beat_cnt_d;
  logic [CNT_W-1:0]   pkt_cnt0_q, pkt_cnt0_d;
  logic [CNT_W-1:0]   pkt_cnt1_q, pkt_cnt1_d;
  logic [CNT_W-1:0]   trunc_cnt_q, trunc_cnt_d;
  logic [CNT_W-1:0]   frame_err_cnt_q, frame_err_cnt_d;

  logic [DATA_W-1:0]  sel_data;
  logic [EMPTY_W-1:0] sel_empty;
  logic               sel_valid, sel_sop, sel_eop;
  logic               cand0, cand1, orphan0, orphan1;
  logic               accept, trunc_hit;

  // Saturating add: counters stick at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] v,
                                               input logic [1:0] n);
    logic [CNT_W:0] sum;
    sum = {1'b0, v} + {{(CNT_W-1){1'b0}}, n};
    sat_add = sum[CNT_W] ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
  endfunction

  // Select the currently granted source's beat.
  always_comb begin
    sel_data  = g_q ? in1_data  : in0_data;
    sel_empty = g_q ? in1_empty : in0_empty;
    sel_valid = g_q ? in1_valid : in0_valid;
    sel_sop   = g_q ? in1_sop   : in0_sop;
    sel_eop   = g_q ? in1_eop   : in0_eop;
  end

  // Orphans are gated by reset so no ready leaks out while reset is held.
  assign cand0     = in0_valid & in0_sop;
  assign cand1     = in1_valid & in1_sop;
  assign orphan0   = core_reset_n & in0_valid & ~in0_sop;
  assign orphan1   = core_reset_n & in1_valid & ~in1_sop;
  assign accept    = sel_valid & out_ready;
  assign trunc_hit = sel_valid & ~sel_eop & (beat_cnt_q == c_last_idx);

  // Next-state, grant selection, watchdog and statistics.
  always_comb begin
    state_d         = state_q;
    g_d             = g_q;
    last_g_d        = last_g_q;
    beat_cnt_d      = beat_cnt_q;
    pkt_cnt0_d      = pkt_cnt0_q;
    pkt_cnt1_d      = pkt_cnt1_q;
    trunc_cnt_d     = trunc_cnt_q;
    frame_err_cnt_d = sat_add(frame_err_cnt_q, 2'd0);
    case (state_q)
      ST_IDLE: begin
        frame_err_cnt_d = sat_add(frame_err_cnt_q,
                                  {1'b0, orphan0} + {1'b0, orphan1});
        if (cand0 | cand1) begin
          // On a tie the source that did not send last wins.
          g_d        = (cand0 & cand1) ? ~last_g_q : cand1;
          state_d    = ST_PASS;
          beat_cnt_d = '0;
        end
      end
      ST_PASS: begin
        if (accept) begin
          if (sel_eop) begin
            // A genuine EOP on the watchdog index is still a normal EOP.
            state_d    = ST_IDLE;
            last_g_d   = g_q;
            beat_cnt_d = '0;
            if (g_q) pkt_cnt1_d = sat_add(pkt_cnt1_q, 2'd1);
            else     pkt_cnt0_d = sat_add(pkt_cnt0_q, 2'd1);
          end else if (beat_cnt_q == c_last_idx) begin
            state_d     = ST_DRAIN;
            trunc_cnt_d = sat_add(trunc_cnt_q, 2'd1);
            beat_cnt_d  = beat_cnt_q + 9'd1;
          end else begin
            beat_cnt_d = beat_cnt_q + 9'd1;
          end
        end
      end
      ST_DRAIN: begin
        if (sel_valid & sel_eop) begin
          state_d    = ST_IDLE;
          last_g_d   = g_q;
          beat_cnt_d = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output mux and backpressure routing; everything is zero outside PASS.
  always_comb begin
    out_valid = 1'b0;
    out_sop   = 1'b0;
    out_eop   = 1'b0;
    out_error = 1'b0;
    out_data  = '0;
    out_empty = '0;
    in0_ready = 1'b0;
    in1_ready = 1'b0;
    case (state_q)
      ST_IDLE: begin
        in0_ready = orphan0;
        in1_ready = orphan1;
      end
      ST_PASS: begin
        out_valid = sel_valid;
        out_data  = sel_data;
        out_sop   = sel_sop & (beat_cnt_q == 9'd0);
        if (trunc_hit) begin
          out_eop   = 1'b1;
          out_error = 1'b1;
        end else begin
          out_eop   = sel_eop;
          out_empty = sel_eop ? sel_empty : '0;
        end
        in0_ready = ~g_q & out_ready;
        in1_ready = g_q & out_ready;
      end
      ST_DRAIN: begin
        in0_ready = ~g_q;
        in1_ready = g_q;
      end
      default: ;
    endcase
  end

  assign grant         = (state_q == ST_IDLE) ? 2'b00 : (g_q ? 2'b10 : 2'b01);
  assign busy          = (state_q != ST_IDLE);
  assign pkt_cnt0      = pkt_cnt0_q;
  assign pkt_cnt1      = pkt_cnt1_q;
  assign trunc_cnt     = trunc_cnt_q;
  assign frame_err_cnt = frame_err_cnt_q;

  // State and counter registers; last_g resets to 1 so in0 wins the first tie.
  always_ff @(posedge sys_clk or negedge core_reset_n) begin
    if (!core_reset_n) begin
      state_q         <= ST_IDLE;
      g_q             <= 1'b0;
      last_g_q        <= 1'b1;
      beat_cnt_q      <= '0;
      pkt_cnt0_q      <= '0;
      pkt_cnt1_q      <= '0;
      trunc_cnt_q     <= '0;
      frame_err_cnt_q <= '0;
    end else begin
      state_q         <= state_d;
      g_q             <= g_d;
      last_g_q        <= last_g_d;
      beat_cnt_q      <= beat_cnt_d;
      pkt_cnt0_q      <= pkt_cnt0_d;
      pkt_cnt1_q      <= pkt_cnt1_d;
      trunc_cnt_q     <= trunc_cnt_d;
      frame_err_cnt_q <= frame_err_cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_tx_pkt_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_tx_pkt_arbiter
// Purpose  : Self-checking bench for tx_pkt_arbiter. Sources replay queued
//            packets with random gaps; a packet-level model predicts the
//            forwarded beats per source, truncation and statistics.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tx_pkt_arbiter;

  localparam int MAX = 380;

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  empty;
    logic        sop;
    logic        eop;
    logic        err;
  } beat_t;

  logic        sys_clk, core_reset_n;
  logic [31:0] s_data [2];
  logic [1:0]  s_empty [2];
  logic [1:0]  s_valid, s_sop, s_eop;
  logic        in0_ready, in1_ready;
  logic [31:0] out_data;
  logic [1:0]  out_empty;
  logic        out_valid, out_sop, out_eop, out_error, out_ready;
  logic [1:0]  grant;
  logic        busy;
  logic [15:0] pkt_cnt0, pkt_cnt1, trunc_cnt, frame_err_cnt;

  tx_pkt_arbiter dut (
    .sys_clk(sys_clk), .core_reset_n(core_reset_n),
    .in0_data(s_data[0]), .in0_empty(s_empty[0]), .in0_valid(s_valid[0]),
    .in0_sop(s_sop[0]), .in0_eop(s_eop[0]), .in0_ready(in0_ready),
    .in1_data(s_data[1]), .in1_empty(s_empty[1]), .in1_valid(s_valid[1]),
    .in1_sop(s_sop[1]), .in1_eop(s_eop[1]), .in1_ready(in1_ready),
    .out_data(out_data), .out_empty(out_empty), .out_valid(out_valid),
    .out_sop(out_sop), .out_eop(out_eop), .out_error(out_error),
    .out_ready(out_ready), .grant(grant), .busy(busy),
    .pkt_cnt0(pkt_cnt0), .pkt_cnt1(pkt_cnt1), .trunc_cnt(trunc_cnt),
    .frame_err_cnt(frame_err_cnt)
  );

  initial begin
    sys_clk = 1'b0;
    forever #5 sys_clk = ~sys_clk;
  end

  int cyc = 0;
  always @(posedge sys_clk) cyc <= cyc + 1;

  // Model state
  beat_t drv_q [2][$];
  beat_t exp_q [2][$];
  int    exp_pkt [2];
  int    exp_trunc, exp_ferr;
  logic  acc [2];
  int    sop_cyc [2];
  int    vprob = 100;
  int    rdy_mode = 0;
  logic  flush = 1'b0;
  logic  draining = 1'b0;
  int    beats_out = 0;
  int    last_lat = -1;
  int    last_eop_cyc = 0;
  int    order_q[$];
  int    gap_q[$];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  // Queue a packet and its expected forwarded image.
  task automatic add_pkt(input int k, input int len);
    beat_t b, e;
    for (int i = 0; i < len; i++) begin
      b.data  = $urandom;
      b.empty = 2'($urandom);
      b.sop   = (i == 0) || ($urandom_range(9) == 0);
      b.eop   = (i == len - 1);
      b.err   = 1'b0;
      drv_q[k].push_back(b);
      if (i < MAX) begin
        e       = b;
        e.sop   = (i == 0);
        e.empty = b.eop ? b.empty : 2'b00;
        if (i == MAX - 1 && !b.eop) begin
          e.eop   = 1'b1;
          e.err   = 1'b1;
          e.empty = 2'b00;
        end
        exp_q[k].push_back(e);
      end
    end
    if (len > MAX) exp_trunc++;
    else exp_pkt[k]++;
  endtask

  task automatic add_orphans(input int k, input int n);
    beat_t b;
    for (int i = 0; i < n; i++) begin
      b.data = $urandom; b.empty = 2'($urandom);
      b.sop = 1'b0; b.eop = 1'($urandom); b.err = 1'b0;
      drv_q[k].push_back(b);
    end
    exp_ferr += n;
  endtask

  // Source and sink drivers: one process owns every driven input.
  initial begin
    beat_t b;
    logic presented [2];
    s_valid = '0; s_sop = '0; s_eop = '0; out_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      s_data[k] = '0; s_empty[k] = '0; presented[k] = 1'b0; acc[k] = 1'b0;
      sop_cyc[k] = 0;
    end
    forever begin
      @(posedge sys_clk);
      #1;
      for (int k = 0; k < 2; k++) begin
        if (flush) begin
          drv_q[k].delete();
          presented[k] = 1'b0;
        end else if (acc[k] && drv_q[k].size() > 0) begin
          void'(drv_q[k].pop_front());
          presented[k] = 1'b0;
        end
        if (!flush && drv_q[k].size() > 0 &&
            (presented[k] || $urandom_range(99) < vprob)) begin
          b = drv_q[k][0];
          if (!presented[k] && b.sop) sop_cyc[k] = cyc;
          presented[k] = 1'b1;
          s_valid[k] = 1'b1; s_data[k] = b.data; s_empty[k] = b.empty;
          s_sop[k] = b.sop; s_eop[k] = b.eop;
        end else begin
          s_valid[k] = 1'b0; s_data[k] = $urandom; s_empty[k] = 2'($urandom);
          s_sop[k] = 1'($urandom); s_eop[k] = 1'($urandom);
        end
      end
      case (rdy_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = ~out_ready;
        default: out_ready = 1'($urandom_range(1));
      endcase
    end
  end

  // Monitor: sampled mid-cycle, away from the active edge.
  always @(negedge sys_clk) begin
    logic [1:0] rdy;
    logic       src;
    beat_t      e;
    rdy = {in1_ready, in0_ready};
    acc[0] = s_valid[0] & in0_ready;
    acc[1] = s_valid[1] & in1_ready;
    if (grant == 2'b00) begin
      check("idle_out_valid", out_valid, 1'b0);
      for (int k = 0; k < 2; k++)
        check("idle_ready", rdy[k], core_reset_n & s_valid[k] & ~s_sop[k]);
    end else begin
      src = grant[1];
      check("grant_onehot", grant[0] ^ grant[1], 1'b1);
      check("other_ready", rdy[~src], 1'b0);
      if (draining) begin
        check("drain_out_valid", out_valid, 1'b0);
        check("drain_ready", rdy[src], 1'b1);
        if (s_valid[src] && rdy[src] && s_eop[src]) draining = 1'b0;
      end else begin
        check("pass_ready", rdy[src], out_ready);
        check("pass_valid", out_valid, s_valid[src]);
        if (out_valid && out_ready) begin
          beats_out++;
          if (exp_q[src].size() == 0) begin
            check("unexpected_beat", 1'b1, 1'b0);
          end else begin
            e = exp_q[src].pop_front();
            check("beat", {out_data, out_empty, out_sop, out_eop, out_error}, e);
          end
          if (out_sop) begin
            last_lat = cyc - sop_cyc[src];
            order_q.push_back(int'(src));
            gap_q.push_back(cyc - last_eop_cyc);
          end
          if (out_eop) last_eop_cyc = cyc;
          if (out_error) draining = 1'b1;
        end
      end
    end
  end

  task automatic wait_done(input string tag, input int budget);
    int n = 0;
    while ((drv_q[0].size() != 0 || drv_q[1].size() != 0 || exp_q[0].size() != 0 ||
            exp_q[1].size() != 0 || busy) && n < budget) begin
      @(negedge sys_clk);
      n++;
    end
    check(tag, n < budget, 1'b1);
    repeat (3) @(negedge sys_clk);
  endtask

  task automatic check_counters(input string tag);
    check({tag, "_pkt_cnt0"}, pkt_cnt0, exp_pkt[0]);
    check({tag, "_pkt_cnt1"}, pkt_cnt1, exp_pkt[1]);
    check({tag, "_trunc_cnt"}, trunc_cnt, exp_trunc);
    check({tag, "_frame_err_cnt"}, frame_err_cnt, exp_ferr);
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_ctl"}, {out_valid, out_sop, out_eop, out_error, busy, grant, in0_ready, in1_ready}, '0);
    check({tag, "_data"}, {out_data, out_empty}, '0);
  endtask

  task automatic do_reset();
    core_reset_n = 1'b0;
    flush = 1'b1;
    exp_q[0].delete(); exp_q[1].delete();
    exp_pkt[0] = 0; exp_pkt[1] = 0; exp_trunc = 0; exp_ferr = 0;
    draining = 1'b0;
    repeat (2) @(negedge sys_clk);
    flush = 1'b0;
    #2 core_reset_n = 1'b1;
    @(negedge sys_clk);
    order_q.delete(); gap_q.delete();
  endtask

  initial begin
    int n, base, k, len;
    core_reset_n = 1'b0;
    #12;
    check_quiet("in_reset");
    do_reset();

    // Reset values
    check_quiet("after_reset");
    check_counters("after_reset");

    // Single source, 16 beats
    rdy_mode = 0; vprob = 100;
    add_pkt(0, 16);
    wait_done("single_done", 200);
    check("single_latency", last_lat, 1);
    check("single_grant_after", grant, 2'b00);
    check_counters("single");

    // Round-robin with both sources continuously offering SOPs
    do_reset();
    add_pkt(0, 4); add_pkt(0, 4); add_pkt(1, 4); add_pkt(1, 4);
    wait_done("rr_done", 200);
    check("rr_count", order_q.size(), 4);
    if (order_q.size() == 4) begin
      check("rr_order", {order_q[0][0], order_q[1][0], order_q[2][0], order_q[3][0]}, 4'b0101);
      for (int i = 1; i < 4; i++) check("rr_gap", gap_q[i], 2);
    end
    check_counters("rr");

    // Backpressure: out_ready toggles every cycle on a 10-beat in1 packet
    rdy_mode = 1;
    add_pkt(1, 10);
    wait_done("bp_done", 200);
    check_counters("bp");

    // Watchdog: 400 beats then EOP from in0, then a normal in1 packet
    rdy_mode = 0;
    add_pkt(0, 401);
    n = 0;
    while (grant != 2'b01 && n < 20) begin @(negedge sys_clk); n++; end
    check("wd_granted", grant, 2'b01);
    add_pkt(1, 6);
    wait_done("wd_done", 2000);
    check_counters("wd");

    // Orphan beats on in1 while idle
    add_orphans(1, 3);
    wait_done("orphan_done", 100);
    check_counters("orphan");

    // Asynchronous reset in the middle of a 12-beat packet
    add_pkt(0, 12);
    base = beats_out; n = 0;
    while (beats_out < base + 4 && n < 100) begin @(negedge sys_clk); n++; end
    check("mid_progress", beats_out - base >= 4, 1'b1);
    #2 core_reset_n = 1'b0;
    #1;
    check_quiet("mid_reset");
    check({pkt_cnt0, pkt_cnt1, trunc_cnt, frame_err_cnt}, 64'd0, 64'd0) ;
    do_reset();
    add_pkt(1, 5);
    wait_done("post_reset_done", 100);
    check("post_reset_latency", last_lat, 1);
    check_counters("post_reset");

    // Randomized mixed traffic with watchdog boundary lengths
    do_reset();
    rdy_mode = 2; vprob = 70;
    add_pkt(0, 380); add_pkt(1, 381); add_pkt(0, 1);
    for (int i = 0; i < 40; i++) begin
      k   = int'($urandom_range(1));
      len = ($urandom_range(9) == 0) ? 370 + int'($urandom_range(20)) : 1 + int'($urandom_range(23));
      add_pkt(k, len);
    end
    wait_done("random_done", 40000);
    check_counters("random");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL global_timeout: got no finish, want finish");
    $fatal(1, "bench time limit reached");
  end

endmodule
`default_nettype wire

// File: doc/tx_pkt_arbiter.md
# tx_pkt_arbiter

Packet-level arbiter sharing the TSE 0 transmit Avalon-ST port between two frame sources: the processed stream from `seaccow_internal` (in0) and a local frame source (in1, e.g. a test-frame or control-frame generator). Grants are round-robin per whole packet and are never switched mid-frame. A beat-count watchdog truncates runaway frames with an error-flagged EOP, then drains the offending source. Sits between the sources and the `tse_0_transmit_*` ports in the top level.

## Interface
- DATA_W, 32, data width; matches the TSE FIFO interface.
- EMPTY_W, 2, empty field width.
- MAX_BEATS, 380, maximum beats per packet (1518 B / 4, rounded up).
- CNT_W, 16, width of the statistics counters.

- sys_clk  in  1  system clock; all logic is on its rising edge.
- core_reset_n  in  1  asynchronous, active-low reset.
- inK_data / inK_empty  in  DATA_W / EMPTY_W  source K beat (K = 0, 1).
- inK_valid, inK_sop, inK_eop  in  1  source K Avalon-ST controls.
- inK_ready  out  1  source K backpressure.
- out_data / out_empty  out  DATA_W / EMPTY_W  to `tse_0_transmit_data` / `tse_0_transmit_empty`.
- out_valid, out_sop, out_eop  out  1  to the TSE transmit port.
- out_error  out  1  to `tse_0_transmit_error`; high only on a truncation EOP.
- out_ready  in  1  from `tse_0_transmit_ready`.
- grant  out  2  one-hot current owner; 00 when idle.
- busy  out  1  high when state ≠ IDLE.
- pkt_cnt0, pkt_cnt1  out  CNT_W  packets fully forwarded per source; saturating.
- trunc_cnt  out  CNT_W  truncated packets; saturating.
- frame_err_cnt  out  CNT_W  orphan non-SOP beats discarded in IDLE; saturating.

## Operation
- **Registered state:** state ∈ {IDLE, PASS, DRAIN}, g (granted index), last_g, beat_cnt (9 bits), counters.
- **IDLE:**
  - out_valid = 0.
  - Candidate K = inK_valid & inK_sop.
  - One candidate: grant it.
  - Both: grant !last_g (round-robin).
  - A grant registers g = K and moves to PASS; inK_ready stays 0 during this cycle.
  - inK_valid & ~inK_sop: orphan beat. Set inK_ready = 1 to discard it, frame_err_cnt++. Only non-candidates are discarded.
- **PASS (combinational pass-through of source g):**
  - out_valid = in_g_valid; in_g_ready = out_ready; the other source's ready = 0.
  - out_sop = in_g_sop & (beat_cnt == 0): mid-packet SOPs are masked.
  - out_empty = in_g_eop ? in_g_empty : 0.
  - out_error = 0, except on a truncation beat.
  - Each accepted beat (valid & ready): beat_cnt++.
- **PASS, accepted beat with in_g_eop:**
  - Next state IDLE; last_g = g; pkt_cnt_g++; beat_cnt = 0.
- **PASS, accepted non-EOP beat with beat_cnt == MAX_BEATS-1 (truncation beat):**
  - out_eop = 1, out_error = 1, out_empty = 0 on that beat.
  - trunc_cnt++; next state DRAIN.
- **DRAIN:**
  - out_valid = 0; in_g_ready = 1; the other source's ready = 0.
  - Accepted EOP: next state IDLE; last_g = g; beat_cnt = 0.
- **Counters:** all saturate at 2^CNT_W−1 and never wrap.
- **Simultaneous events:** an EOP on the truncation-index beat is a normal EOP. No error, pkt_cnt increments, no DRAIN.

## Timing
- **Reset values:**
  - state = IDLE, last_g = 1 (so in0 wins the first tie), beat_cnt = 0.
  - All counters 0; grant = 00; busy = 0; out_valid = out_sop = out_eop = out_error = 0; inK_ready = 0.
  - out_data / out_empty = 0 (outputs muxed to 0 when not in PASS).
- **Grant latency:** SOP valid in IDLE at cycle t → grant/busy high at t+1 → first transfer at t+1 at the earliest.
- **Pass-through latency:** zero cycles for data and ready.
- **Inter-packet gap:** EOP accepted at t → IDLE at t+1 → next grant at t+2. Minimum 1 idle cycle on out_valid between packets.
- **Backpressure:** beats hold while out_ready = 0; the watchdog counts accepted beats only.
- **Reset mid-packet:** immediate return to IDLE with outputs 0. The downstream packet is left without EOP, which is tolerated by design (MAC flush).
- **Handshake contract:** a source must hold data stable while valid & ~ready. The arbiter does not sample unaccepted beats.

## Test plan
- **Single source:** in0 sends a 16-beat packet, out_ready = 1.
  - Out is identical to in0; first beat at t+1; pkt_cnt0 = 1; grant = 01 during the packet, 00 after.
- **Round-robin:** both sources hold SOP valid continuously, 4-beat packets.
  - Output order is in0, in1, in0, in1.
  - 1 idle cycle between packets; pkt_cnt0 = pkt_cnt1 = 2 after 4 packets.
- **Backpressure:** out_ready toggles 1/0 every cycle during a 10-beat in1 packet.
  - in1_ready mirrors out_ready; all 10 beats appear once, in order; empty appears only on EOP.
- **Watchdog:** in0 sends 400 beats without EOP.
  - Beat 380 carries out_eop = 1, out_error = 1; trunc_cnt = 1.
  - Beats 381–400 plus EOP are drained with out_valid = 0; next in1 packet is granted normally.
- **Orphans:** in1 presents 3 non-SOP beats while IDLE.
  - All discarded; frame_err_cnt = 3; out_valid stays 0.
- **Mid-packet reset:** assert core_reset_n low at beat 5 of 12.
  - All outputs 0 asynchronously; counters 0; after release, the next SOP is granted within 1 cycle.
